button_event_decoder: RTL and testbench

BUTTON_EVENT_DECODER -- requirements
Module: button_event_decoder

---
 rtl/button_event_decoder.sv | 126 ++++++++++++
 tb/tb_button_event_decoder.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/button_event_decoder.sv
// Turns a debounced button level into press/short/long/repeat/release strobes; all strobes registered, one cycle after the edge/tick.
// Auto-repeat while held is built only when BUTTON_AUTOREPEAT_EN is defined; otherwise o_repeat_stb is tied low.
module button_event_decoder #(
  parameter int LONG_TICKS   = 1000,
  parameter int REPEAT_TICKS = 200
) (
  input  logic i_clk,
  input  logic i_reset_n,
  input  logic i_en,
  input  logic i_tick_stb,
  input  logic i_button_state,
  output logic o_press_stb,
  output logic o_short_stb,
  output logic o_long_stb,
  output logic o_repeat_stb,
  output logic o_release_stb,
  output logic o_held
);

  typedef enum logic [1:0] {IDLE, PRESSED, HELD} state_t;

  localparam logic [15:0] LONG_CNT = 16'(LONG_TICKS);

  if (LONG_TICKS < 1 || LONG_TICKS > 65535 ||
      REPEAT_TICKS < 1 || REPEAT_TICKS > 65535) begin : g_bad_param
    $error("button_event_decoder: LONG_TICKS/REPEAT_TICKS must be in 1..65535");
  end

  state_t      state;
  logic [15:0] tick_cnt;
  logic        prev_state;
  logic        rise;
  logic        fall;
  logic [15:0] cnt_inc;

  assign rise    = i_button_state & ~prev_state;
  assign fall    = ~i_button_state & prev_state;
  // Counter is cleared on every state entry and compared before the bump, so it never wraps.
  assign cnt_inc = tick_cnt + 16'd1;

`ifdef BUTTON_AUTOREPEAT_EN
  localparam logic [15:0] REPEAT_CNT = 16'(REPEAT_TICKS);
  logic repeat_q;
  assign o_repeat_stb = repeat_q;
`else
  assign o_repeat_stb = 1'b0;
`endif

  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      state         <= IDLE;
      tick_cnt      <= 16'd0;
      prev_state    <= 1'b0;
      o_press_stb   <= 1'b0;
      o_short_stb   <= 1'b0;
      o_long_stb    <= 1'b0;
      o_release_stb <= 1'b0;
      o_held        <= 1'b0;
`ifdef BUTTON_AUTOREPEAT_EN
      repeat_q      <= 1'b0;
`endif
    end else begin
      o_press_stb   <= 1'b0;
      o_short_stb   <= 1'b0;
      o_long_stb    <= 1'b0;
      o_release_stb <= 1'b0;
`ifdef BUTTON_AUTOREPEAT_EN
      repeat_q      <= 1'b0;
`endif
      if (i_en) begin
        prev_state <= i_button_state;
        case (state)
          IDLE: begin
            if (rise) begin
              state       <= PRESSED;
              tick_cnt    <= 16'd0;
              o_press_stb <= 1'b1;
            end
          end
          PRESSED: begin
            // Release takes priority over a threshold tick landing in the same cycle.
            if (fall) begin
              state         <= IDLE;
              tick_cnt      <= 16'd0;
              o_short_stb   <= 1'b1;
              o_release_stb <= 1'b1;
            end else if (i_tick_stb) begin
              if (cnt_inc == LONG_CNT) begin
                state      <= HELD;
                tick_cnt   <= 16'd0;
                o_long_stb <= 1'b1;
                o_held     <= 1'b1;
              end else begin
                tick_cnt <= cnt_inc;
              end
            end
          end
          HELD: begin
            if (fall) begin
              state         <= IDLE;
              tick_cnt      <= 16'd0;
              o_release_stb <= 1'b1;
              o_held        <= 1'b0;
            end
`ifdef BUTTON_AUTOREPEAT_EN
            else if (i_tick_stb) begin
              if (cnt_inc == REPEAT_CNT) begin
                tick_cnt <= 16'd0;
                repeat_q <= 1'b1;
              end else begin
                tick_cnt <= cnt_inc;
              end
            end
`endif
          end
          default: begin
            state    <= IDLE;
            tick_cnt <= 16'd0;
            o_held   <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_button_event_decoder.sv
// Directed scenarios plus randomized run, checked each cycle against an event-level model of the button.
module tb_button_event_decoder;
  localparam int LT = 4;
  localparam int RT = 2;
`ifdef BUTTON_AUTOREPEAT_EN
  localparam bit AR = 1'b1;
`else
  localparam bit AR = 1'b0;
`endif

  logic i_clk = 1'b0;
  logic i_reset_n, i_en, i_tick_stb, i_button_state;
  logic o_press_stb, o_short_stb, o_long_stb, o_repeat_stb, o_release_stb, o_held;

  button_event_decoder #(.LONG_TICKS(LT), .REPEAT_TICKS(RT)) dut (
    .i_clk          (i_clk),
    .i_reset_n      (i_reset_n),
    .i_en           (i_en),
    .i_tick_stb     (i_tick_stb),
    .i_button_state (i_button_state),
    .o_press_stb    (o_press_stb),
    .o_short_stb    (o_short_stb),
    .o_long_stb     (o_long_stb),
    .o_repeat_stb   (o_repeat_stb),
    .o_release_stb  (o_release_stb),
    .o_held         (o_held)
  );

  always #5 i_clk = ~i_clk;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  // Model: whether a press is in progress, how many enabled ticks it has lasted, last seen level.
  bit         m_active = 1'b0;
  bit         m_last = 1'b0;
  int         m_ticks = 0;
  logic [5:0] m_out = 6'b0;

  int n_press, n_short, n_long, n_rep, n_rel, n_held;
  int press_cyc = 0;
  int long_cyc = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, got, exp);
    end
  endtask

  task automatic clr();
    n_press = 0; n_short = 0; n_long = 0; n_rep = 0; n_rel = 0; n_held = 0;
  endtask

  task automatic model(input bit rst_n, input bit en, input bit btn, input bit tick);
    bit p, s, l, r, rl, rise, fall;
    p = 0; s = 0; l = 0; r = 0; rl = 0;
    if (!rst_n) begin
      m_active = 0; m_ticks = 0; m_last = 0;
      m_out = 6'b0;
    end else if (!en) begin
      m_out = {5'b0, m_out[0]};
    end else begin
      rise = btn && !m_last;
      fall = !btn && m_last;
      m_last = btn;
      if (!m_active) begin
        if (rise) begin
          m_active = 1; m_ticks = 0; p = 1;
        end
      end else if (fall) begin
        rl = 1;
        s = (m_ticks < LT);
        m_active = 0; m_ticks = 0;
      end else if (tick) begin
        m_ticks++;
        if (m_ticks == LT) l = 1;
        else if (AR && m_ticks > LT && ((m_ticks - LT) % RT) == 0) r = 1;
      end
      m_out = {p, s, l, r, rl, (m_active && m_ticks >= LT)};
    end
  endtask

  task automatic step(input bit rst_n, input bit en, input bit btn, input bit tick);
    logic [5:0] got;
    i_reset_n = rst_n; i_en = en; i_button_state = btn; i_tick_stb = tick;
    model(rst_n, en, btn, tick);
    @(posedge i_clk);
    #1;
    cyc++;
    got = {o_press_stb, o_short_stb, o_long_stb, o_repeat_stb, o_release_stb, o_held};
    chk("outputs", {26'b0, got}, {26'b0, m_out});
    if (o_press_stb === 1'b1) begin n_press++; press_cyc = cyc; end
    if (o_short_stb === 1'b1) n_short++;
    if (o_long_stb === 1'b1) begin n_long++; long_cyc = cyc; end
    if (o_repeat_stb === 1'b1) n_rep++;
    if (o_release_stb === 1'b1) n_rel++;
    if (o_held === 1'b1) n_held++;
  endtask

  initial begin
    i_reset_n = 1'b0; i_en = 1'b0; i_tick_stb = 1'b0; i_button_state = 1'b0;
    clr();
    step(0, 0, 0, 0);
    step(0, 1, 0, 0);
    chk("reset_held", {31'b0, o_held}, 32'd0);

    // Short press: release after two ticks.
    clr();
    step(1, 1, 1, 0);
    step(1, 1, 1, 1);
    step(1, 1, 1, 1);
    step(1, 1, 0, 0);
    step(1, 1, 0, 0);
    chk("s1_press", n_press, 1);
    chk("s1_short", n_short, 1);
    chk("s1_release", n_rel, 1);
    chk("s1_long", n_long, 0);
    chk("s1_held", n_held, 0);

    // Hold for nine ticks: long after tick 4, repeats after 6 and 8 when enabled.
    clr();
    step(1, 1, 1, 0);
    for (int i = 0; i < 9; i++) step(1, 1, 1, 1);
    step(1, 1, 0, 0);
    step(1, 1, 0, 0);
    chk("s2_long", n_long, 1);
    chk("s2_long_lat", long_cyc - press_cyc, 4);
    chk("s2_repeat", n_rep, AR ? 2 : 0);
    chk("s2_short", n_short, 0);
    chk("s2_release", n_rel, 1);
    chk("s2_held_cycles", n_held, 6);

    // Fall coincides with the threshold tick: release wins.
    clr();
    step(1, 1, 1, 0);
    for (int i = 0; i < 3; i++) step(1, 1, 1, 1);
    step(1, 1, 0, 1);
    step(1, 1, 0, 0);
    chk("s4_short", n_short, 1);
    chk("s4_release", n_rel, 1);
    chk("s4_long", n_long, 0);
    chk("s4_held", n_held, 0);

    // Enable low for ten cycles mid-press with ticks present.
    clr();
    step(1, 1, 1, 0);
    step(1, 1, 1, 1);
    step(1, 1, 1, 1);
    clr();
    for (int i = 0; i < 10; i++) step(1, 0, 1, 1);
    chk("s5_frozen_strobes", n_press + n_short + n_long + n_rep + n_rel, 0);
    chk("s5_tick_cnt", {16'b0, dut.tick_cnt}, m_ticks);
    step(1, 1, 1, 1);
    step(1, 1, 1, 1);
    chk("s5_long", n_long, 1);
    chk("s5_long_lat", long_cyc - press_cyc, 14);
    step(1, 1, 0, 0);
    step(1, 1, 0, 0);

    // Reset while held with the button still down.
    clr();
    step(1, 1, 1, 0);
    for (int i = 0; i < 4; i++) step(1, 1, 1, 1);
    chk("s6_held_before", {31'b0, o_held}, 32'd1);
    step(0, 0, 1, 1);
    step(0, 1, 1, 1);
    chk("s6_rst_held", {31'b0, o_held}, 32'd0);
    clr();
    step(1, 1, 1, 0);
    step(1, 1, 1, 0);
    chk("s6_press", n_press, 1);
    chk("s6_release", n_rel, 0);
    step(1, 1, 0, 0);

    // Randomized traffic.
    begin
      bit btn;
      btn = 1'b0;
      for (int i = 0; i < 3000; i++) begin
        if ($urandom_range(0, 9) == 0) btn = ~btn;
        step(($urandom_range(0, 299) != 0), ($urandom_range(0, 7) != 0),
             btn, ($urandom_range(0, 1) == 1));
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1000000;
    failures++;
    $display("FAIL timeout cyc=%0d", cyc);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "timeout");
  end

endmodule
